// File: rtl/sat_bin_pkg.sv
// Shared widths, slot counts, FSM encoding and lvl-state layout for the
// bin loader / bin store pair.
package sat_bin_pkg;

    localparam int NUM_VARS_A_BIN        = 8;
    localparam int NUM_LVLS_A_BIN        = 8;
    localparam int WIDTH_VAR             = 12;
    localparam int WIDTH_LVL             = 16;
    localparam int WIDTH_BIN_ID          = 10;
    localparam int WIDTH_VAR_STATES      = 19;
    localparam int WIDTH_LVL_STATES      = 11;
    localparam int ADDR_WIDTH_VAR        = 9;
    localparam int ADDR_WIDTH_VAR_STATES = 9;
    localparam int ADDR_WIDTH_LVL_STATES = 9;

    // Slot index width; both slot counts are 8.
    localparam int WIDTH_SLOT    = 3;
    localparam int WIDTH_DCD_BIN = WIDTH_LVL_STATES - 1;

    localparam logic [WIDTH_SLOT-1:0] LAST_SLOT  = 3'd7;
    localparam logic [WIDTH_SLOT-1:0] DRAIN_LAST = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_VID   = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_STORE_LS = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    typedef struct packed {
        logic [WIDTH_DCD_BIN-1:0] dcd_bin;
        logic                     has_bkt;
    } lvl_state_t;

endpackage

// File: rtl/select_from_8_datas.sv
// Index-driven slice mux: picks one WIDTH-bit word out of eight packed words
// (word 0 in the LSBs). Gather counterpart of the loader's scatter.
module select_from_8_datas #(
    parameter int WIDTH = 8
) (
    input  logic [8*WIDTH-1:0] i_datas,
    input  logic [2:0]         i_sel,
    output logic [WIDTH-1:0]   o_data
);

    assign o_data = i_datas[i_sel*WIDTH +: WIDTH];

endmodule

// File: rtl/store_bin.sv
// Bin write-back: snapshots the engine's var/lvl states on start, writes var
// states to the var-state BRAM through the var-id BRAM, then writes lvl states
// to the lvl-state BRAM from base_lvl up to cur_lvl.
module store_bin
    import sat_bin_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_store_i,
    input  logic [WIDTH_BIN_ID-1:0]                    request_bin_num_i,
    input  logic [WIDTH_LVL-1:0]                       base_lvl_i,
    input  logic [WIDTH_LVL-1:0]                       cur_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] var_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_states_i,
    output logic                                       apply_store_o,
    output logic                                       done_store_o,
    output logic [ADDR_WIDTH_VAR-1:0]                  ram_addr_v_o,
    input  logic [WIDTH_VAR-1:0]                       ram_data_v_i,
    output logic                                       ram_we_vs_o,
    output logic [ADDR_WIDTH_VAR_STATES-1:0]           ram_addr_vs_o,
    output logic [WIDTH_VAR_STATES-1:0]                ram_data_vs_o,
    output logic                                       ram_we_ls_o,
    output logic [ADDR_WIDTH_LVL_STATES-1:0]           ram_addr_ls_o,
    output logic [WIDTH_LVL_STATES-1:0]                ram_data_ls_o
);

    state_t                                     r_state;
    logic [WIDTH_SLOT-1:0]                      r_cnt;
    logic                                       r_apply;
    logic                                       r_done;

    logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] r_var_snap;
    logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] r_lvl_snap;
    logic [WIDTH_LVL-1:0]                       r_base_lvl;
    logic [WIDTH_LVL-1:0]                       r_cur_lvl;
    logic [ADDR_WIDTH_VAR-1:0]                  r_addr_v;

    logic                                       r_vld_p1;
    logic [WIDTH_SLOT-1:0]                      r_slot_p1;
    logic                                       r_we_vs_p2;
    logic [ADDR_WIDTH_VAR_STATES-1:0]           r_addr_vs_p2;
    logic [WIDTH_VAR_STATES-1:0]                r_data_vs_p2;

    logic                                       r_we_ls;
    logic [ADDR_WIDTH_LVL_STATES-1:0]           r_addr_ls;
    lvl_state_t                                 r_data_ls;

    logic [WIDTH_BIN_ID+WIDTH_SLOT-1:0]         w_vbase_full;
    logic                                       w_unused_vbase;
    logic [WIDTH_VAR_STATES-1:0]                w_vs_word;
    logic [WIDTH_LVL_STATES-1:0]                w_ls_word;
    logic                                       w_ls_issue;
    logic [WIDTH_SLOT-1:0]                      w_ls_idx;
    logic [WIDTH_LVL:0]                         w_ls_sum;
    logic                                       w_start;

    assign w_start      = (r_state == ST_IDLE) && start_store_i;
    // First var-id address of the bin; high bits fall off with the truncation.
    assign w_vbase_full = {request_bin_num_i, {WIDTH_SLOT{1'b0}}};
    assign w_unused_vbase = ^w_vbase_full[WIDTH_BIN_ID+WIDTH_SLOT-1:ADDR_WIDTH_VAR];

    select_from_8_datas #(.WIDTH(WIDTH_VAR_STATES)) u_sel_vs (
        .i_datas (r_var_snap),
        .i_sel   (r_slot_p1),
        .o_data  (w_vs_word)
    );

    select_from_8_datas #(.WIDTH(WIDTH_LVL_STATES)) u_sel_ls (
        .i_datas (r_lvl_snap),
        .i_sel   (w_ls_idx),
        .o_data  (w_ls_word)
    );

    // Lvl slot to issue next: slot 0 on the last drain cycle, then one per STORE_LS cycle.
    always_comb begin
        w_ls_issue = 1'b0;
        w_ls_idx   = '0;
        if (r_state == ST_DRAIN && r_cnt == DRAIN_LAST) begin
            w_ls_issue = 1'b1;
        end else if (r_state == ST_STORE_LS && r_cnt != LAST_SLOT) begin
            w_ls_issue = 1'b1;
            w_ls_idx   = r_cnt + 3'd1;
        end
    end

    // One bit wider than a level so base_lvl + slot never wraps before the compare.
    assign w_ls_sum = {1'b0, r_base_lvl} + {{(WIDTH_LVL+1-WIDTH_SLOT){1'b0}}, w_ls_idx};

    // Sequencer: read ids, drain the id pipeline, store lvls, pulse done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_apply <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_store_i) begin
                        r_state <= ST_RD_VID;
                        r_cnt   <= '0;
                        r_apply <= 1'b1;
                    end
                end
                ST_RD_VID: begin
                    if (r_cnt == LAST_SLOT) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == DRAIN_LAST) begin
                        r_state <= ST_STORE_LS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_STORE_LS: begin
                    if (r_cnt == LAST_SLOT) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_apply <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Snapshot engine state on an accepted start; step the var-id read address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_var_snap <= '0;
            r_lvl_snap <= '0;
            r_base_lvl <= '0;
            r_cur_lvl  <= '0;
            r_addr_v   <= '0;
        end else if (w_start) begin
            r_var_snap <= var_states_i;
            r_lvl_snap <= lvl_states_i;
            r_base_lvl <= base_lvl_i;
            r_cur_lvl  <= cur_lvl_i;
            r_addr_v   <= w_vbase_full[ADDR_WIDTH_VAR-1:0];
        end else if (r_state == ST_RD_VID) begin
            r_addr_v <= r_addr_v + 9'd1;
        end
    end

    // Var path: p1 tracks the slot whose id the BRAM is returning, p2 drives the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p1     <= 1'b0;
            r_slot_p1    <= '0;
            r_we_vs_p2   <= 1'b0;
            r_addr_vs_p2 <= '0;
            r_data_vs_p2 <= '0;
        end else begin
            r_vld_p1     <= (r_state == ST_RD_VID);
            r_slot_p1    <= r_cnt;
            r_we_vs_p2   <= r_vld_p1 && (ram_data_v_i != '0);
            r_addr_vs_p2 <= ram_data_v_i[ADDR_WIDTH_VAR_STATES-1:0];
            r_data_vs_p2 <= w_vs_word;
        end
    end

    // Lvl path: write only levels up to cur_lvl.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we_ls   <= 1'b0;
            r_addr_ls <= '0;
            r_data_ls <= '0;
        end else begin
            r_we_ls   <= w_ls_issue && (w_ls_sum <= {1'b0, r_cur_lvl});
            r_addr_ls <= w_ls_sum[ADDR_WIDTH_LVL_STATES-1:0];
            r_data_ls <= w_ls_word;
        end
    end

    assign apply_store_o = r_apply;
    assign done_store_o  = r_done;
    assign ram_addr_v_o  = r_addr_v;
    assign ram_we_vs_o   = r_we_vs_p2;
    assign ram_addr_vs_o = r_addr_vs_p2;
    assign ram_data_vs_o = r_data_vs_p2;
    assign ram_we_ls_o   = r_we_ls;
    assign ram_addr_ls_o = r_addr_ls;
    assign ram_data_ls_o = r_data_ls;

endmodule

// File: tb/tb_store_bin.sv
// Directed bench for store_bin: a behavioural var-id BRAM plus a write logger,
// with one task per scenario comparing logged writes to hand-computed values.
module tb_store_bin;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_store_i;
    logic [9:0]   request_bin_num_i;
    logic [15:0]  base_lvl_i;
    logic [15:0]  cur_lvl_i;
    logic [151:0] var_states_i;
    logic [87:0]  lvl_states_i;
    logic         apply_store_o;
    logic         done_store_o;
    logic [8:0]   ram_addr_v_o;
    logic [11:0]  ram_data_v_i;
    logic         ram_we_vs_o;
    logic [8:0]   ram_addr_vs_o;
    logic [18:0]  ram_data_vs_o;
    logic         ram_we_ls_o;
    logic [8:0]   ram_addr_ls_o;
    logic [10:0]  ram_data_ls_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [11:0] vid_mem [512];

    logic [18:0] VS_W [8] = '{19'h00A11, 19'h01B22, 19'h02C33, 19'h03D44,
                              19'h04E55, 19'h05F66, 19'h06077, 19'h07188};
    logic [10:0] LS_W [8] = '{11'h101, 11'h202, 11'h303, 11'h404,
                              11'h505, 11'h606, 11'h707, 11'h0F8};
    logic [151:0] vs_bus;
    logic [87:0]  ls_bus;

    int          vs_cyc_q [$];
    logic [8:0]  vs_addr_q[$];
    logic [18:0] vs_data_q[$];
    int          ls_cyc_q [$];
    logic [8:0]  ls_addr_q[$];
    logic [10:0] ls_data_q[$];
    int          done_q   [$];
    int          apply_q  [$];

    store_bin dut (
        .clk               (clk),
        .rst               (rst),
        .start_store_i     (start_store_i),
        .request_bin_num_i (request_bin_num_i),
        .base_lvl_i        (base_lvl_i),
        .cur_lvl_i         (cur_lvl_i),
        .var_states_i      (var_states_i),
        .lvl_states_i      (lvl_states_i),
        .apply_store_o     (apply_store_o),
        .done_store_o      (done_store_o),
        .ram_addr_v_o      (ram_addr_v_o),
        .ram_data_v_i      (ram_data_v_i),
        .ram_we_vs_o       (ram_we_vs_o),
        .ram_addr_vs_o     (ram_addr_vs_o),
        .ram_data_vs_o     (ram_data_vs_o),
        .ram_we_ls_o       (ram_we_ls_o),
        .ram_addr_ls_o     (ram_addr_ls_o),
        .ram_data_ls_o     (ram_data_ls_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Var-id BRAM, one cycle read latency.
    always @(posedge clk) ram_data_v_i <= vid_mem[ram_addr_v_o];

    // Log every write and status cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_we_vs_o) begin
            vs_cyc_q.push_back(cyc);
            vs_addr_q.push_back(ram_addr_vs_o);
            vs_data_q.push_back(ram_data_vs_o);
        end
        if (ram_we_ls_o) begin
            ls_cyc_q.push_back(cyc);
            ls_addr_q.push_back(ram_addr_ls_o);
            ls_data_q.push_back(ram_data_ls_o);
        end
        if (done_store_o)  done_q.push_back(cyc);
        if (apply_store_o) apply_q.push_back(cyc);
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        vs_cyc_q.delete(); vs_addr_q.delete(); vs_data_q.delete();
        ls_cyc_q.delete(); ls_addr_q.delete(); ls_data_q.delete();
        done_q.delete(); apply_q.delete();
    endtask

    // Drive one start pulse; t0 is the cycle in which start is high.
    task automatic start_op(input logic [9:0] bin, input logic [15:0] base,
                            input logic [15:0] cur, output int t0);
        @(negedge clk);
        start_store_i     = 1'b1;
        request_bin_num_i = bin;
        base_lvl_i        = base;
        cur_lvl_i         = cur;
        var_states_i      = vs_bus;
        lvl_states_i      = ls_bus;
        t0 = cyc;
        @(negedge clk);
        start_store_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_store_i = 1'b0;
        request_bin_num_i = '0; base_lvl_i = '0; cur_lvl_i = '0;
        var_states_i = '0; lvl_states_i = '0;
        run(3);
        checks++; if (apply_store_o !== 1'b0) begin errors++; $display("FAIL reset_apply: got %b want 0", apply_store_o); end
        checks++; if (done_store_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_store_o); end
        checks++; if (ram_we_vs_o !== 1'b0) begin errors++; $display("FAIL reset_we_vs: got %b want 0", ram_we_vs_o); end
        checks++; if (ram_we_ls_o !== 1'b0) begin errors++; $display("FAIL reset_we_ls: got %b want 0", ram_we_ls_o); end
        checks++; if (ram_addr_v_o !== 9'd0) begin errors++; $display("FAIL reset_addr_v: got %0h want 0", ram_addr_v_o); end
        checks++; if (ram_addr_vs_o !== 9'd0 || ram_data_vs_o !== 19'd0) begin errors++; $display("FAIL reset_vs_bus: got %0h/%0h want 0/0", ram_addr_vs_o, ram_data_vs_o); end
        checks++; if (ram_addr_ls_o !== 9'd0 || ram_data_ls_o !== 11'd0) begin errors++; $display("FAIL reset_ls_bus: got %0h/%0h want 0/0", ram_addr_ls_o, ram_data_ls_o); end
        rst = 1'b1;
        run(1);
    endtask

    task automatic test_var_store();
        int t0;
        logic [8:0] ids [8] = '{9'd5, 9'd9, 9'd13, 9'd17, 9'd21, 9'd25, 9'd29, 9'd33};
        for (int i = 0; i < 8; i++) vid_mem[24+i] = {3'b000, ids[i]};
        clear_logs();
        start_op(10'd3, 16'd0, 16'd7, t0);
        run(24);
        checks++; if (vs_addr_q.size() !== 8) begin errors++; $display("FAIL vs_count: got %0d want 8", vs_addr_q.size()); end
        for (int i = 0; i < 8 && i < vs_addr_q.size(); i++) begin
            checks++; if (vs_addr_q[i] !== ids[i]) begin errors++; $display("FAIL vs_addr[%0d]: got %0d want %0d", i, vs_addr_q[i], ids[i]); end
            checks++; if (vs_data_q[i] !== VS_W[i]) begin errors++; $display("FAIL vs_data[%0d]: got %0h want %0h", i, vs_data_q[i], VS_W[i]); end
            checks++; if (vs_cyc_q[i] !== t0 + 3 + i) begin errors++; $display("FAIL vs_cycle[%0d]: got T+%0d want T+%0d", i, vs_cyc_q[i] - t0, 3 + i); end
        end
        checks++; if (ls_addr_q.size() !== 8) begin errors++; $display("FAIL ls_count_full: got %0d want 8", ls_addr_q.size()); end
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL done_count: got %0d want 1", done_q.size()); end
        if (done_q.size() > 0) begin
            checks++; if (done_q[0] !== t0 + 19) begin errors++; $display("FAIL done_cycle: got T+%0d want T+19", done_q[0] - t0); end
        end
        checks++; if (apply_q.size() !== 19) begin errors++; $display("FAIL apply_len: got %0d want 19", apply_q.size()); end
        if (apply_q.size() > 0) begin
            checks++; if (apply_q[0] !== t0 + 1) begin errors++; $display("FAIL apply_first: got T+%0d want T+1", apply_q[0] - t0); end
        end
    endtask

    task automatic test_empty_slots();
        int t0;
        logic [11:0] ids [8] = '{12'd7, 12'd8, 12'd0, 12'd10, 12'd11, 12'd12, 12'd0, 12'd14};
        logic [8:0]  exp_addr [6] = '{9'd7, 9'd8, 9'd10, 9'd11, 9'd12, 9'd14};
        int          exp_slot [6] = '{0, 1, 3, 4, 5, 7};
        for (int i = 0; i < 8; i++) vid_mem[40+i] = ids[i];
        clear_logs();
        start_op(10'd5, 16'd0, 16'd7, t0);
        run(24);
        checks++; if (vs_addr_q.size() !== 6) begin errors++; $display("FAIL empty_count: got %0d want 6", vs_addr_q.size()); end
        for (int i = 0; i < 6 && i < vs_addr_q.size(); i++) begin
            checks++; if (vs_addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL empty_addr[%0d]: got %0d want %0d", i, vs_addr_q[i], exp_addr[i]); end
            checks++; if (vs_data_q[i] !== VS_W[exp_slot[i]]) begin errors++; $display("FAIL empty_data[%0d]: got %0h want %0h", i, vs_data_q[i], VS_W[exp_slot[i]]); end
            checks++; if (vs_cyc_q[i] !== t0 + 3 + exp_slot[i]) begin errors++; $display("FAIL empty_cycle[%0d]: got T+%0d want T+%0d", i, vs_cyc_q[i] - t0, 3 + exp_slot[i]); end
        end
    endtask

    task automatic test_lvl_store();
        int t0;
        clear_logs();
        start_op(10'd3, 16'd4, 16'd8, t0);
        run(24);
        checks++; if (ls_addr_q.size() !== 5) begin errors++; $display("FAIL ls_count: got %0d want 5", ls_addr_q.size()); end
        for (int j = 0; j < 5 && j < ls_addr_q.size(); j++) begin
            checks++; if (ls_addr_q[j] !== 9'(4 + j)) begin errors++; $display("FAIL ls_addr[%0d]: got %0d want %0d", j, ls_addr_q[j], 4 + j); end
            checks++; if (ls_data_q[j] !== LS_W[j]) begin errors++; $display("FAIL ls_data[%0d]: got %0h want %0h", j, ls_data_q[j], LS_W[j]); end
            checks++; if (ls_cyc_q[j] !== t0 + 11 + j) begin errors++; $display("FAIL ls_cycle[%0d]: got T+%0d want T+%0d", j, ls_cyc_q[j] - t0, 11 + j); end
        end
        // Near the top of the level range: only base and base+1 fit under cur_lvl.
        clear_logs();
        start_op(10'd3, 16'hFFFE, 16'hFFFF, t0);
        run(24);
        checks++; if (ls_addr_q.size() !== 2) begin errors++; $display("FAIL ls_nowrap_count: got %0d want 2", ls_addr_q.size()); end
        if (ls_addr_q.size() == 2) begin
            checks++; if (ls_addr_q[0] !== 9'h1FE || ls_addr_q[1] !== 9'h1FF) begin errors++; $display("FAIL ls_nowrap_addr: got %0h,%0h want 1fe,1ff", ls_addr_q[0], ls_addr_q[1]); end
        end
    endtask

    task automatic test_snapshot();
        int t0;
        for (int i = 0; i < 8; i++) vid_mem[8+i] = 12'(100 + i);
        clear_logs();
        start_op(10'd1, 16'd10, 16'd17, t0);
        for (int k = 0; k < 20; k++) begin
            var_states_i      = ~var_states_i;
            lvl_states_i      = ~lvl_states_i;
            base_lvl_i        = ~base_lvl_i;
            cur_lvl_i         = ~cur_lvl_i;
            request_bin_num_i = request_bin_num_i ^ 10'h3FF;
            run(1);
        end
        run(4);
        checks++; if (vs_addr_q.size() !== 8) begin errors++; $display("FAIL snap_vs_count: got %0d want 8", vs_addr_q.size()); end
        for (int i = 0; i < 8 && i < vs_addr_q.size(); i++) begin
            checks++; if (vs_addr_q[i] !== 9'(100 + i) || vs_data_q[i] !== VS_W[i]) begin errors++; $display("FAIL snap_vs[%0d]: got %0d/%0h want %0d/%0h", i, vs_addr_q[i], vs_data_q[i], 100 + i, VS_W[i]); end
        end
        checks++; if (ls_addr_q.size() !== 8) begin errors++; $display("FAIL snap_ls_count: got %0d want 8", ls_addr_q.size()); end
        for (int j = 0; j < 8 && j < ls_addr_q.size(); j++) begin
            checks++; if (ls_addr_q[j] !== 9'(10 + j) || ls_data_q[j] !== LS_W[j]) begin errors++; $display("FAIL snap_ls[%0d]: got %0d/%0h want %0d/%0h", j, ls_addr_q[j], ls_data_q[j], 10 + j, LS_W[j]); end
        end
    endtask

    task automatic test_reset_abort();
        int t0;
        int late;
        clear_logs();
        start_op(10'd3, 16'd0, 16'd7, t0);
        run(5);
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        checks++; if ({apply_store_o, done_store_o, ram_we_vs_o, ram_we_ls_o} !== 4'b0000 || ram_addr_v_o !== 9'd0) begin errors++; $display("FAIL abort_outputs: got ap=%b dn=%b wv=%b wl=%b av=%0h want all 0", apply_store_o, done_store_o, ram_we_vs_o, ram_we_ls_o, ram_addr_v_o); end
        run(24);
        late = 0;
        foreach (vs_cyc_q[i]) if (vs_cyc_q[i] >= t0 + 7) late++;
        checks++; if (late !== 0) begin errors++; $display("FAIL abort_late_vs: got %0d want 0", late); end
        checks++; if (vs_cyc_q.size() !== 4) begin errors++; $display("FAIL abort_early_vs: got %0d want 4", vs_cyc_q.size()); end
        checks++; if (ls_addr_q.size() !== 0 || done_q.size() !== 0) begin errors++; $display("FAIL abort_ls_done: got %0d/%0d want 0/0", ls_addr_q.size(), done_q.size()); end
        clear_logs();
        start_op(10'd3, 16'd0, 16'd7, t0);
        run(24);
        checks++; if (vs_addr_q.size() !== 8 || ls_addr_q.size() !== 8) begin errors++; $display("FAIL after_abort_writes: got %0d/%0d want 8/8", vs_addr_q.size(), ls_addr_q.size()); end
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL after_abort_done: got %0d want 1", done_q.size()); end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        clear_logs();
        start_op(10'd3, 16'd0, 16'd7, t0);
        run(4);
        start_store_i = 1'b1;
        request_bin_num_i = 10'd1;
        run(1);
        start_store_i = 1'b0;
        run(14);
        start_store_i = 1'b1;
        request_bin_num_i = 10'd5;
        t1 = cyc;
        run(1);
        start_store_i = 1'b0;
        run(24);
        checks++; if (t1 !== t0 + 20) begin errors++; $display("FAIL b2b_start_cycle: got T+%0d want T+20", t1 - t0); end
        checks++; if (done_q.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_q.size()); end
        if (done_q.size() == 2) begin
            checks++; if (done_q[0] !== t0 + 19 || done_q[1] !== t0 + 39) begin errors++; $display("FAIL b2b_done_cycles: got T+%0d,T+%0d want T+19,T+39", done_q[0] - t0, done_q[1] - t0); end
        end
        checks++; if (vs_addr_q.size() !== 14) begin errors++; $display("FAIL b2b_vs_count: got %0d want 14", vs_addr_q.size()); end
        if (vs_addr_q.size() == 14) begin
            checks++; if (vs_addr_q[0] !== 9'd5 || vs_addr_q[7] !== 9'd33) begin errors++; $display("FAIL busy_start_ignored: got %0d..%0d want 5..33", vs_addr_q[0], vs_addr_q[7]); end
            checks++; if (vs_addr_q[8] !== 9'd7 || vs_cyc_q[8] !== t0 + 23) begin errors++; $display("FAIL b2b_second_first: got %0d@T+%0d want 7@T+23", vs_addr_q[8], vs_cyc_q[8] - t0); end
        end
        checks++; if (apply_q.size() !== 38) begin errors++; $display("FAIL b2b_apply_len: got %0d want 38", apply_q.size()); end
    endtask

    initial begin
        for (int a = 0; a < 512; a++) vid_mem[a] = '0;
        for (int i = 0; i < 8; i++) begin
            vs_bus[i*19 +: 19] = VS_W[i];
            ls_bus[i*11 +: 11] = LS_W[i];
        end
        test_reset();
        test_var_store();
        test_empty_slots();
        test_lvl_store();
        test_snapshot();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
